// File: rtl/stream_burst_source.sv
// stream_burst_source
//
// Transmitter end of the valid/ready stream protocol. It accepts burst commands
// (start value, step, length) on a command handshake. For each command it emits
// the arithmetic sequence start, start+step, ... on the out_* stream and marks
// the final beat with out_last. Back-to-back bursts run without a bubble,
// because the last beat's transfer cycle can accept the next command.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   cmd_valid     command offered
//   cmd_ready     command accepted when cmd_valid && cmd_ready (combinational)
//   cmd_start     data value of the first beat
//   cmd_step      increment added per beat (wraps modulo 2^DATA_WIDTH)
//   cmd_len       beats minus one
//   out_valid     output beat present (registered)
//   out_ready     downstream can accept
//   out_data      beat payload (registered)
//   out_last      final beat of the current burst (registered)
//   busy          burst in progress, identical to out_valid
//   stall_count   saturating count of stalled cycles in the current/most recent burst

module stream_burst_source #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned STALL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DATA_WIDTH-1:0]  cmd_start,
  input  logic [DATA_WIDTH-1:0]  cmd_step,
  input  logic [LEN_WIDTH-1:0]   cmd_len,

  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_last,

  output logic                   busy,
  output logic [STALL_WIDTH-1:0] stall_count
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                 state_q;
  logic [DATA_WIDTH-1:0]  step_q;
  logic [LEN_WIDTH-1:0]   remaining_q;

  logic out_xfer;
  logic cmd_xfer;

  assign out_xfer = out_valid && out_ready;

  // The final beat's transfer cycle doubles as a command slot, which is what
  // removes the idle cycle between consecutive bursts.
  assign cmd_ready = (state_q == StIdle) || (out_xfer && out_last);
  assign cmd_xfer  = cmd_valid && cmd_ready;

  assign busy = out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      step_q      <= '0;
      remaining_q <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      stall_count <= '0;
    end else if (cmd_xfer) begin
      // cmd_xfer only happens in IDLE or on the last beat's transfer, so a
      // load here never overwrites a beat that is still pending.
      state_q     <= StSend;
      out_valid   <= 1'b1;
      out_data    <= cmd_start;
      step_q      <= cmd_step;
      remaining_q <= cmd_len;
      out_last    <= (cmd_len == '0);
      stall_count <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          // Nothing held; out_data and stall_count keep their last values.
        end
        StSend: begin
          if (out_xfer) begin
            if (out_last) begin
              state_q   <= StIdle;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_data    <= out_data + step_q;
              remaining_q <= remaining_q - 1'b1;
              out_last    <= (remaining_q == LEN_WIDTH'(1));
            end
          end else if (stall_count != '1) begin
            stall_count <= stall_count + 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_burst_source.sv
// Self-checking bench for stream_burst_source. Expected beats are computed from
// each command and pushed to a queue when the command is accepted. The monitor
// pops and compares an entry on every output transfer. The monitor also checks
// that a stalled beat is held stable, that busy equals out_valid, and that
// cmd_ready follows its defining equation.
module tb_stream_burst_source;

  localparam int DW = 32;
  localparam int LW = 8;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_start;
  logic [DW-1:0] cmd_step;
  logic [LW-1:0] cmd_len;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [SW-1:0] stall_count;

  stream_burst_source #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .STALL_WIDTH(SW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_step   (cmd_step),
    .cmd_len    (cmd_len),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [DW-1:0] start;
    logic [DW-1:0] step;
    logic [LW-1:0] len;
    int            mode;       // 0 ready high, 1 random, 2 stall window
    int            exp_stall;  // -1: not checked
  } vec_t;

  beat_t         exp_q[$];
  vec_t          vecs[5];
  int            checks = 0;
  int            errors = 0;
  int            beats_seen;
  int            ready_mode;
  logic [DW-1:0] stall_val;
  int            stall_left;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive out_ready for the coming cycle; called just after each rising edge.
  task automatic update_ready();
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && out_data == stall_val && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  endtask

  task automatic sample();
    beat_t b;
    if (!rst_n) begin
      prev_stall = 1'b0;
      return;
    end
    chk("busy_eq_valid", 64'(busy), 64'(out_valid));
    chk("cmd_ready_eq", 64'(cmd_ready), 64'(!out_valid || (out_ready && out_last)));
    if (prev_stall) begin
      chk("stall_hold_valid", 64'(out_valid), 64'd1);
      chk("stall_hold_data", 64'(out_data), 64'(prev_data));
      chk("stall_hold_last", 64'(out_last), 64'(prev_last));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(out_data), 64'hDEAD_0000_0000_0000);
      end else begin
        b = exp_q.pop_front();
        chk("beat_data", 64'(out_data), 64'(b.data));
        chk("beat_last", 64'(out_last), 64'(b.last));
        beats_seen++;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
  endtask

  task automatic tick(output logic rdy_seen);
    @(negedge clk);
    sample();
    rdy_seen = cmd_ready;
    @(posedge clk);
    #1;
    update_ready();
  endtask

  task automatic send_cmd(input logic [DW-1:0] start, input logic [DW-1:0] step,
                          input logic [LW-1:0] len, output int waited);
    logic          r;
    logic          acc;
    logic [DW-1:0] v;
    beats_seen = 0;
    cmd_start  = start;
    cmd_step   = step;
    cmd_len    = len;
    cmd_valid  = 1'b1;
    acc        = 1'b0;
    waited     = -1;
    for (int i = 0; i < 200 && !acc; i++) begin
      tick(r);
      if (r) begin
        acc    = 1'b1;
        waited = i;
      end
    end
    cmd_valid = 1'b0;
    cmd_start = $urandom;
    cmd_step  = $urandom;
    cmd_len   = LW'($urandom);
    if (!acc) begin
      chk("cmd_accept_timeout", 64'd0, 64'd1);
    end else begin
      v = start;
      for (int i = 0; i <= int'(len); i++) begin
        exp_q.push_back('{data: v, last: (i == int'(len))});
        v = v + step;
      end
      chk("first_beat_valid", 64'(out_valid), 64'd1);
      chk("first_beat_data", 64'(out_data), 64'(start));
    end
  endtask

  task automatic wait_done();
    logic r;
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
      else tick(r);
    end
    if (!done) begin
      chk("burst_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    logic r;
    int   w;

    vecs[0] = '{start: 32'h10,        step: 32'd1,        len: 8'd3,   mode: 0, exp_stall: 0};
    vecs[1] = '{start: 32'h10,        step: 32'd1,        len: 8'd3,   mode: 2, exp_stall: 3};
    vecs[2] = '{start: 32'hFFFF_FFFE, step: 32'd1,        len: 8'd3,   mode: 0, exp_stall: 0};
    vecs[3] = '{start: 32'h0,         step: 32'd2,        len: 8'hFF,  mode: 1, exp_stall: -1};
    vecs[4] = '{start: 32'h5,         step: 32'hFFFF_FFFF, len: 8'd0,  mode: 0, exp_stall: 0};

    rst_n      = 1'b0;
    cmd_valid  = 1'b1;  // offered during reset; must not be taken
    cmd_start  = 32'hABCD;
    cmd_step   = 32'd1;
    cmd_len    = 8'd2;
    out_ready  = 1'b1;
    ready_mode = 0;
    stall_val  = '0;
    stall_left = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    beats_seen = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall_count", 64'(stall_count), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(out_valid), 64'd0);

    // Table-driven bursts.
    for (int k = 0; k < 5; k++) begin
      ready_mode = vecs[k].mode;
      stall_val  = 32'h11;
      stall_left = 3;
      update_ready();
      send_cmd(vecs[k].start, vecs[k].step, vecs[k].len, w);
      wait_done();
      chk("beat_count", 64'(beats_seen), 64'(int'(vecs[k].len) + 1));
      if (vecs[k].exp_stall >= 0)
        chk("stall_count", 64'(stall_count), 64'(vecs[k].exp_stall));
    end

    // Back-to-back: B is held valid and must be taken on A's last transfer.
    ready_mode = 0;
    update_ready();
    send_cmd(32'h0, 32'd4, 8'd1, w);
    send_cmd(32'h100, 32'd1, 8'd0, w);
    chk("b2b_accept_cycle", 64'(w), 64'd1);
    wait_done();
    chk("b2b_stall_count", 64'(stall_count), 64'd0);

    // Reset in the middle of a burst.
    send_cmd(32'h40, 32'd3, 8'd7, w);
    tick(r);
    tick(r);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_last", 64'(out_last), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    exp_q.delete();
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      tick(r);
      chk("midrst_no_residual", 64'(out_valid), 64'd0);
    end
    send_cmd(32'h77, 32'd1, 8'd2, w);
    wait_done();
    chk("midrst_new_count", 64'(beats_seen), 64'd3);

    // Idle with out_ready toggling: no output activity.
    ready_mode = 1;
    for (int i = 0; i < 12; i++) begin
      tick(r);
      chk("idle_quiet", 64'(out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
